// File: rtl/pixel_stream_receiver.sv
// Pixel stream sink: checks framing against the programmed image size and
// turns accepted pixels into linear frame-buffer writes through a single
// registered write stage with backpressure.
module pixel_stream_receiver #(
    parameter int ADDR_W = 26,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [12:0]       image_width,
    input  logic [12:0]       image_height,
    input  logic              in_valid,
    input  logic              in_sof,
    input  logic              in_eol,
    input  logic [7:0]        in_red,
    input  logic [7:0]        in_green,
    input  logic [7:0]        in_blue,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [23:0]       wr_data,
    input  logic              wr_ready,
    output logic              frame_done,
    output logic [CNT_W-1:0]  frame_count,
    output logic [2:0]        err_flags,
    input  logic              err_clear
);

    typedef enum logic {IDLE, RECV} state_t;

    state_t            state, state_nxt;
    logic [12:0]       w_q, h_q, w_nxt, h_nxt;
    logic [12:0]       x_q, y_q, x_nxt, y_nxt;
    logic [ADDR_W-1:0] lb_q, lb_nxt;
    logic              wr_final;

    logic              accept;
    logic              beat_write;
    logic              beat_final;
    logic              line_end;
    logic [ADDR_W-1:0] beat_addr;
    logic [2:0]        err_set;

    // A new beat may enter whenever the write register is empty or draining.
    assign in_ready   = !wr_en || wr_ready;
    assign accept     = in_valid && in_ready;
    assign frame_done = wr_en && wr_ready && wr_final;

    // Framing decisions for the beat being accepted this cycle.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned (which would infer a latch).
        state_nxt  = state;
        w_nxt      = w_q;
        h_nxt      = h_q;
        x_nxt      = x_q;
        y_nxt      = y_q;
        lb_nxt     = lb_q;
        beat_write = 1'b0;
        beat_final = 1'b0;
        beat_addr  = '0;
        err_set    = 3'b000;
        line_end   = 1'b0;
        if (accept) begin
            if (in_sof) begin
                // A SOF always restarts the frame; mid-frame it is also an error.
                if (state == RECV) err_set[2] = 1'b1;
                w_nxt = image_width;
                h_nxt = image_height;
                if (image_width == 13'd0 || image_height == 13'd0) begin
                    state_nxt = IDLE;
                end else begin
                    beat_write = 1'b1;
                    if (image_width == 13'd1) begin
                        // One-pixel-wide image: the SOF beat closes its line.
                        x_nxt  = 13'd0;
                        y_nxt  = 13'd1;
                        lb_nxt = ADDR_W'(1);
                        if (image_height == 13'd1) begin
                            beat_final = 1'b1;
                            state_nxt  = IDLE;
                        end else begin
                            state_nxt = RECV;
                        end
                    end else begin
                        x_nxt     = 13'd1;
                        y_nxt     = 13'd0;
                        lb_nxt    = '0;
                        state_nxt = RECV;
                    end
                end
            end else if (state == RECV) begin
                beat_write = 1'b1;
                beat_addr  = lb_q + ADDR_W'(x_q);
                if (x_q == w_q - 13'd1) begin
                    line_end = 1'b1;
                    if (!in_eol) err_set[1] = 1'b1;
                end else if (in_eol) begin
                    line_end   = 1'b1;
                    err_set[0] = 1'b1;
                end
                if (line_end) begin
                    x_nxt  = 13'd0;
                    y_nxt  = y_q + 13'd1;
                    lb_nxt = lb_q + ADDR_W'(w_q);
                    if (y_q == h_q - 13'd1) begin
                        beat_final = 1'b1;
                        state_nxt  = IDLE;
                    end
                end else begin
                    x_nxt = x_q + 13'd1;
                end
            end
        end
    end

    // Framing state and position counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            w_q   <= '0;
            h_q   <= '0;
            x_q   <= '0;
            y_q   <= '0;
            lb_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state <= state_nxt;
            w_q   <= w_nxt;
            h_q   <= h_nxt;
            x_q   <= x_nxt;
            y_q   <= y_nxt;
            lb_q  <= lb_nxt;
        end
    end

    // Write register: loads on an accepted written beat, holds while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            wr_final <= 1'b0;
        end else if (accept && beat_write) begin
            wr_en    <= 1'b1;
            wr_addr  <= beat_addr;
            wr_data  <= {in_red, in_green, in_blue};
            wr_final <= beat_final;
        end else if (wr_en && wr_ready) begin
            wr_en    <= 1'b0;
            wr_final <= 1'b0;
        end
    end

    // Frame counter and sticky error flags; a new error beats a clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_count <= '0;
            err_flags   <= 3'b000;
        end else begin
            if (beat_final) frame_count <= frame_count + CNT_W'(1);
            err_flags <= (err_clear ? 3'b000 : err_flags) | err_set;
        end
    end

endmodule

// File: tb/tb_pixel_stream_receiver.sv
// Self-checking bench for pixel_stream_receiver: a frame-level model predicts
// every frame-buffer write, a monitor compares each completed write.
module tb_pixel_stream_receiver;

    localparam int ADDR_W = 26;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [12:0]       image_width, image_height;
    logic              in_valid, in_sof, in_eol;
    logic [7:0]        in_red, in_green, in_blue;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [23:0]       wr_data;
    logic              wr_ready;
    logic              frame_done;
    logic [CNT_W-1:0]  frame_count;
    logic [2:0]        err_flags;
    logic              err_clear;

    pixel_stream_receiver #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .image_width(image_width), .image_height(image_height),
        .in_valid(in_valid), .in_sof(in_sof), .in_eol(in_eol),
        .in_red(in_red), .in_green(in_green), .in_blue(in_blue),
        .in_ready(in_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .frame_done(frame_done), .frame_count(frame_count),
        .err_flags(err_flags), .err_clear(err_clear)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [23:0]       data;
        bit                fin;
    } wr_t;

    wr_t               exp_q[$];
    wr_t               cur;
    logic [ADDR_W-1:0] addr_log[$];
    int                expv[$];
    int                n_cmp = 0;
    int                n_bad = 0;
    int                done_pulses = 0;

    // Frame-level model state
    bit       m_active;
    int       m_col, m_row, m_w, m_h, m_frames;
    logic [2:0] m_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Predict the effect of one accepted beat: pixel (col,row) lands at row*W+col.
    function automatic void model_accept(bit sof, bit eol, logic [23:0] d);
        bit  sof_beat = 0;
        bit  last, fin;
        wr_t w;
        if (sof) begin
            if (m_active) m_err[2] = 1'b1;
            m_w = int'(image_width);
            m_h = int'(image_height);
            if (m_w == 0 || m_h == 0) begin
                m_active = 0;
                return;
            end
            m_active = 1;
            m_col = 0;
            m_row = 0;
            sof_beat = 1;
        end else if (!m_active) begin
            return;
        end
        last = (m_col == m_w - 1) || (eol && !sof_beat);
        if (!sof_beat) begin
            if (m_col == m_w - 1 && !eol) m_err[1] = 1'b1;
            if (m_col <  m_w - 1 &&  eol) m_err[0] = 1'b1;
        end
        fin    = last && (m_row == m_h - 1);
        w.addr = ADDR_W'(m_row * m_w + m_col);
        w.data = d;
        w.fin  = fin;
        exp_q.push_back(w);
        if (last) begin
            m_col = 0;
            m_row++;
        end else begin
            m_col++;
        end
        if (fin) begin
            m_active = 0;
            m_frames++;
        end
    endfunction

    // Monitor: every completed write must be the next predicted one.
    always @(negedge clk) begin
        if (!reset) begin
            check("in_ready_rule", in_ready, !wr_en || wr_ready);
            if (wr_en && wr_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", wr_addr, '1);
                end else begin
                    cur = exp_q.pop_front();
                    check("wr_addr", wr_addr, cur.addr);
                    check("wr_data", wr_data, cur.data);
                    check("frame_done", frame_done, cur.fin);
                    addr_log.push_back(wr_addr);
                end
            end else begin
                check("frame_done_idle", frame_done, 0);
            end
            if (frame_done) done_pulses++;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #1;
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_frame_count", frame_count, 0);
        check("rst_err_flags", err_flags, 0);
        exp_q.delete();
        m_active = 0;
        m_err    = 3'b000;
        m_frames = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Present one beat and hold it until accepted (bounded).
    task automatic send(input bit sof, input bit eol, input logic [23:0] d);
        bit ok = 0;
        int i = 0;
        in_valid = 1'b1;
        in_sof   = sof;
        in_eol   = eol;
        {in_red, in_green, in_blue} = d;
        while (!ok && i < 50) begin
            @(negedge clk);
            if (in_ready) begin
                model_accept(sof, eol, d);
                ok = 1;
            end
            i++;
        end
        if (!ok) check("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_eol   = 1'b0;
    endtask

    task automatic clear_err();
        err_clear = 1'b1;
        @(posedge clk);
        #1;
        err_clear = 1'b0;
        m_err = 3'b000;
    endtask

    task automatic check_log(input string nm);
        check({nm, "_len"}, addr_log.size(), expv.size());
        for (int i = 0; i < expv.size() && i < addr_log.size(); i++)
            check(nm, addr_log[i], expv[i]);
    endtask

    task automatic check_model(input string nm);
        check({nm, "_err_model"}, err_flags, m_err);
        check({nm, "_cnt_model"}, frame_count, CNT_W'(m_frames));
    endtask

    function automatic logic [23:0] pix(input int k);
        return 24'hA05000 + 24'(k * 24'h010203);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        image_width = 13'd4; image_height = 13'd2;
        in_valid = 0; in_sof = 0; in_eol = 0;
        in_red = 0; in_green = 0; in_blue = 0;
        wr_ready = 1'b1; err_clear = 1'b0;
        apply_reset();

        // Clean 4x2 frame
        addr_log.delete();
        for (int k = 0; k < 8; k++) begin
            send(k == 0, k == 3 || k == 7, pix(k));
            if (k == 7) check("t1_done_timing", frame_done, 1);
        end
        idle(3);
        expv = '{0, 1, 2, 3, 4, 5, 6, 7};
        check_log("t1_addr");
        check("t1_done_pulses", done_pulses, 1);
        check("t1_frame_count", frame_count, 1);
        check("t1_err", err_flags, 3'b000);
        check_model("t1");

        // Same frame with three stalled cycles after beat 2
        addr_log.delete();
        for (int k = 0; k < 8; k++) begin
            send(k == 0, k == 3 || k == 7, pix(k + 8));
            if (k == 2) begin
                wr_ready = 1'b0;
                #1;
                check("t2_stall_ready", in_ready, 0);
                fork
                    begin
                        repeat (3) @(posedge clk);
                        #1;
                        wr_ready = 1'b1;
                    end
                join_none
            end
        end
        idle(3);
        check_log("t2_addr");
        check("t2_done_pulses", done_pulses, 2);
        check("t2_frame_count", frame_count, 2);

        // Early EOL at x=1
        addr_log.delete();
        for (int k = 0; k < 6; k++) send(k == 0, k == 1 || k == 5, pix(k + 16));
        idle(3);
        expv = '{0, 1, 4, 5, 6, 7};
        check_log("t3_addr");
        check("t3_err", err_flags, 3'b001);
        check("t3_done_pulses", done_pulses, 3);
        check_model("t3");

        // Late EOL, then SOF mid-frame coinciding with err_clear
        clear_err();
        check("t4_cleared", err_flags, 3'b000);
        addr_log.delete();
        for (int k = 0; k < 4; k++) send(k == 0, 1'b0, pix(k + 24));
        check("t4_late", err_flags, 3'b010);
        check_model("t4a");
        send(1'b0, 1'b0, pix(28));
        err_clear = 1'b1;
        m_err = 3'b000;
        send(1'b1, 1'b0, pix(29));
        err_clear = 1'b0;
        check("t4_sof_beats_clear", err_flags, 3'b100);
        check_model("t4b");
        idle(3);
        expv = '{0, 1, 2, 3, 4, 0};
        check_log("t4_addr");
        clear_err();
        check("t4_clear_all", err_flags, 3'b000);

        // No SOF yet, and a zero-width SOF: nothing is written
        apply_reset();
        addr_log.delete();
        send(1'b0, 1'b0, pix(40));
        send(1'b0, 1'b1, pix(41));
        check("t5_ready", in_ready, 1);
        image_width = 13'd0;
        send(1'b1, 1'b0, pix(42));
        send(1'b0, 1'b0, pix(43));
        idle(3);
        check("t5_writes", addr_log.size(), 0);
        check("t5_wr_en", wr_en, 0);
        check("t5_frame_count", frame_count, 0);

        // 1x1 frame
        image_width = 13'd1; image_height = 13'd1;
        send(1'b1, 1'b1, pix(50));
        check("t6_done_timing", frame_done, 1);
        idle(3);
        expv = '{0};
        check_log("t6_addr");
        check("t6_frame_count", frame_count, 1);
        check_model("t6");

        // Reset mid-frame, then a fresh frame starts at address 0
        image_width = 13'd4; image_height = 13'd2;
        addr_log.delete();
        for (int k = 0; k < 3; k++) send(k == 0, 1'b0, pix(k + 60));
        apply_reset();
        addr_log.delete();
        for (int k = 0; k < 8; k++) send(k == 0, k == 3 || k == 7, pix(k + 70));
        idle(3);
        expv = '{0, 1, 2, 3, 4, 5, 6, 7};
        check_log("t7_addr");
        check("t7_frame_count", frame_count, 1);
        check_model("t7");
        check("end_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
